// File: rtl/axil_pkg.sv
// Shared widths, AXI response codes and sequencer state encoding for the AXI4-Lite command path.
package axil_pkg;

    localparam int unsigned AXIL_ADDR_W = 24;
    localparam int unsigned AXIL_DATA_W = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_B,
        WAIT_R
    } seq_state_t;

endpackage

// File: rtl/axil_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; a push into a full FIFO is refused
// even when a pop happens in the same cycle.
module axil_cmd_fifo #(
    parameter int unsigned WIDTH = 57,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/axil_cmd_sequencer.sv
// Queues write/read commands and issues them one at a time to axil_master, returning one
// response beat per command from the monitored B/R handshakes or the watchdog.
module axil_cmd_sequencer
    import axil_pkg::*;
#(
    parameter int unsigned ADDR_W  = AXIL_ADDR_W,
    parameter int unsigned DATA_W  = AXIL_DATA_W,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic                   m_axi_aclk,
    input  logic                   m_axi_areset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [ADDR_W-1:0]      cmd_addr,
    input  logic [DATA_W-1:0]      cmd_wdata,
    output logic [$clog2(DEPTH):0] cmd_count,
    output logic                   write,
    output logic [ADDR_W-1:0]      write_address,
    output logic [DATA_W-1:0]      write_data,
    output logic                   read,
    output logic [ADDR_W-1:0]      read_address,
    input  logic [DATA_W-1:0]      read_data,
    input  logic                   mon_bvalid,
    input  logic                   mon_bready,
    input  logic [1:0]             mon_bresp,
    input  logic                   mon_rvalid,
    input  logic                   mon_rready,
    input  logic [DATA_W-1:0]      mon_rdata,
    input  logic [1:0]             mon_rresp,
    output logic                   rsp_valid,
    output logic                   rsp_write,
    output logic [1:0]             rsp_resp,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_timeout,
    output logic                   busy
);

    localparam int unsigned CMD_W = 1 + ADDR_W + DATA_W;
    localparam int unsigned WD_W  = $clog2(TIMEOUT);

    seq_state_t        state_q;
    logic [WD_W-1:0]   wdog_q;
    logic              cmd_write_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [DATA_W-1:0] cmd_data_q;
    logic              write_q;
    logic              read_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              rsp_valid_q;
    logic              rsp_write_q;
    logic [1:0]        rsp_resp_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_timeout_q;

    logic [CMD_W-1:0]  head_c;
    logic              fifo_full_c;
    logic              fifo_empty_c;
    logic              pop_c;
    logic              b_hs_c;
    logic              r_hs_c;
    logic              wdog_expired_c;
    logic              unused_read_data;

    // Read data comes from the R monitor port; the master's read_data output is not needed.
    assign unused_read_data = ^read_data;

    assign pop_c          = (state_q == IDLE) && !fifo_empty_c;
    assign b_hs_c         = mon_bvalid && mon_bready;
    assign r_hs_c         = mon_rvalid && mon_rready;
    assign wdog_expired_c = (wdog_q == WD_W'(TIMEOUT - 1));

    axil_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (m_axi_aclk),
        .rst_i   (m_axi_areset),
        .push_i  (cmd_valid),
        .wdata_i ({cmd_write, cmd_addr, cmd_wdata}),
        .pop_i   (pop_c),
        .rdata_o (head_c),
        .full_o  (fifo_full_c),
        .empty_o (fifo_empty_c),
        .count_o (cmd_count)
    );

    // Sequencer FSM, watchdog and response registers; handshake takes priority over timeout.
    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            state_q       <= IDLE;
            wdog_q        <= '0;
            cmd_write_q   <= 1'b0;
            cmd_addr_q    <= '0;
            cmd_data_q    <= '0;
            write_q       <= 1'b0;
            read_q        <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            rd_addr_q     <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_write_q   <= 1'b0;
            rsp_resp_q    <= '0;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            write_q     <= 1'b0;
            read_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty_c) begin
                        cmd_write_q <= head_c[CMD_W-1];
                        cmd_addr_q  <= head_c[CMD_W-2 -: ADDR_W];
                        cmd_data_q  <= head_c[DATA_W-1:0];
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    wdog_q <= '0;
                    if (cmd_write_q) begin
                        write_q   <= 1'b1;
                        wr_addr_q <= cmd_addr_q;
                        wr_data_q <= cmd_data_q;
                        state_q   <= WAIT_B;
                    end else begin
                        read_q    <= 1'b1;
                        rd_addr_q <= cmd_addr_q;
                        state_q   <= WAIT_R;
                    end
                end
                WAIT_B: begin
                    if (b_hs_c || wdog_expired_c) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_write_q   <= 1'b1;
                        rsp_resp_q    <= b_hs_c ? mon_bresp : RESP_SLVERR;
                        rsp_rdata_q   <= '0;
                        rsp_timeout_q <= !b_hs_c;
                        state_q       <= IDLE;
                    end else begin
                        wdog_q <= wdog_q + WD_W'(1);
                    end
                end
                WAIT_R: begin
                    if (r_hs_c || wdog_expired_c) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_write_q   <= 1'b0;
                        rsp_resp_q    <= r_hs_c ? mon_rresp : RESP_SLVERR;
                        rsp_rdata_q   <= r_hs_c ? mon_rdata : '0;
                        rsp_timeout_q <= !r_hs_c;
                        state_q       <= IDLE;
                    end else begin
                        wdog_q <= wdog_q + WD_W'(1);
                    end
                end
            endcase
        end
    end

    assign cmd_ready     = !fifo_full_c;
    assign busy          = (state_q != IDLE) || !fifo_empty_c;
    assign write         = write_q;
    assign write_address = wr_addr_q;
    assign write_data    = wr_data_q;
    assign read          = read_q;
    assign read_address  = rd_addr_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_write     = rsp_write_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_timeout   = rsp_timeout_q;

endmodule

// File: tb/tb_axil_cmd_sequencer.sv
// Scoreboard bench for axil_cmd_sequencer: an AXI-Lite slave stub answers the pulses, a
// reference memory model predicts every pulse and response beat.
module tb_axil_cmd_sequencer;

    localparam int unsigned AW      = 24;
    localparam int unsigned DW      = 32;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 8;

    logic          clk;
    logic          m_axi_areset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [2:0]    cmd_count;
    logic          write;
    logic [AW-1:0] write_address;
    logic [DW-1:0] write_data;
    logic          read;
    logic [AW-1:0] read_address;
    logic [DW-1:0] read_data;
    logic          mon_bvalid, mon_bready;
    logic [1:0]    mon_bresp;
    logic          mon_rvalid, mon_rready;
    logic [DW-1:0] mon_rdata;
    logic [1:0]    mon_rresp;
    logic          rsp_valid, rsp_write, rsp_timeout, busy;
    logic [1:0]    rsp_resp;
    logic [DW-1:0] rsp_rdata;

    axil_cmd_sequencer #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .m_axi_aclk(clk), .m_axi_areset(m_axi_areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_count(cmd_count),
        .write(write), .write_address(write_address), .write_data(write_data),
        .read(read), .read_address(read_address), .read_data(read_data),
        .mon_bvalid(mon_bvalid), .mon_bready(mon_bready), .mon_bresp(mon_bresp),
        .mon_rvalid(mon_rvalid), .mon_rready(mon_rready), .mon_rdata(mon_rdata),
        .mon_rresp(mon_rresp),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_resp(rsp_resp),
        .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout), .busy(busy)
    );

    typedef struct { bit w; bit [1:0] resp; bit [31:0] rdata; bit to; } rsp_t;
    typedef struct { bit w; bit [23:0] a; bit [31:0] d; } pulse_t;
    typedef struct { bit drop; } stub_t;

    rsp_t      exp_q[$];
    pulse_t    pulse_q[$];
    stub_t     stub_q[$];
    bit [31:0] model_mem [bit [23:0]];
    bit [31:0] stub_mem  [bit [23:0]];

    int total, bad, cyc, rsp_cnt, force_delay, inject_req, inject_done, rst_epoch;

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: in-order execution, address bit 23 decodes to DECERR, dropped commands time out.
    function automatic void model_cmd(bit w, bit [23:0] a, bit [31:0] d, bit drop);
        rsp_t e; pulse_t p; stub_t s;
        p.w = w; p.a = a; p.d = d;
        pulse_q.push_back(p);
        s.drop = drop;
        stub_q.push_back(s);
        e.w = w; e.to = drop; e.rdata = 32'h0; e.resp = 2'b00;
        if (drop) e.resp = 2'b10;
        else if (a[23]) begin
            e.resp = 2'b11;
            if (!w) e.rdata = 32'hDEADBEEF;
        end else if (w) model_mem[a] = d;
        else if (model_mem.exists(a)) e.rdata = model_mem[a];
        exp_q.push_back(e);
    endfunction

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push_cmd(input bit w, input bit [23:0] a, input bit [31:0] d, input bit drop);
        int n;
        n = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 500);
        check("push_accept", 64'(cmd_ready), 64'(1));
        if (cmd_ready) model_cmd(w, a, d, drop);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(exp_q.size() == 0 && !busy), 64'(1));
        @(posedge clk);
        #1;
    endtask

    // AXI-Lite slave stub driving the B/R monitor ports.
    initial begin
        stub_t s; bit is_w; bit [23:0] a; bit [31:0] dd; int dly;
        mon_bvalid = 0; mon_bready = 0; mon_bresp = 0;
        mon_rvalid = 0; mon_rready = 0; mon_rdata = 0; mon_rresp = 0;
        forever begin
            @(negedge clk);
            if (inject_req != inject_done) begin
                inject_done++;
                mon_rvalid = 1; mon_rready = 1; mon_rdata = 32'hBAD0BAD0; mon_rresp = 2'b00;
                @(negedge clk);
                mon_rvalid = 0; mon_rready = 0;
            end else if ((write || read) && stub_q.size() > 0) begin
                s = stub_q.pop_front();
                is_w = write;
                a = write ? write_address : read_address;
                dd = write_data;
                if (!s.drop) begin
                    dly = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 4));
                    repeat (dly) begin
                        if (is_w) begin mon_bvalid = 1'($urandom % 2); mon_bready = 0; end
                        else      begin mon_rvalid = 0; mon_rready = 1'($urandom % 2); end
                        @(negedge clk);
                    end
                    if (is_w) begin
                        if (!a[23]) stub_mem[a] = dd;
                        mon_bvalid = 1; mon_bready = 1; mon_bresp = a[23] ? 2'b11 : 2'b00;
                    end else begin
                        mon_rvalid = 1; mon_rready = 1;
                        mon_rresp = a[23] ? 2'b11 : 2'b00;
                        mon_rdata = a[23] ? 32'hDEADBEEF : (stub_mem.exists(a) ? stub_mem[a] : 32'h0);
                    end
                    @(negedge clk);
                    mon_bvalid = 0; mon_bready = 0; mon_rvalid = 0; mon_rready = 0;
                end
            end
        end
    end

    // Monitor: pops predicted pulses and responses whenever the DUT presents them.
    initial begin
        int seen_epoch; bit outst; rsp_t e; pulse_t p;
        seen_epoch = 0; outst = 0;
        forever begin
            @(negedge clk);
            if (seen_epoch != rst_epoch) begin
                seen_epoch = rst_epoch;
                outst = 0;
            end
            if (m_axi_areset) continue;
            if (write || read) begin
                check("pulse_one_hot", 64'(write && read), 64'(0));
                check("one_outstanding", 64'(outst), 64'(0));
                outst = 1;
                if (pulse_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_pulse: write=%0b read=%0b (cycle %0d)", write, read, cyc);
                end else begin
                    p = pulse_q.pop_front();
                    check("pulse_type", 64'(write), 64'(p.w));
                    check("pulse_addr", 64'(write ? write_address : read_address), 64'(p.a));
                    if (p.w) check("pulse_wdata", 64'(write_data), 64'(p.d));
                end
            end
            if (rsp_valid) begin
                rsp_cnt++;
                outst = 0;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_rsp: resp=%0h rdata=%0h (cycle %0d)", rsp_resp, rsp_rdata, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_write", 64'(rsp_write), 64'(e.w));
                    check("rsp_resp", 64'(rsp_resp), 64'(e.resp));
                    check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                    check("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
                end
            end
        end
    end

    initial begin
        int n, c1, c2;
        bit [23:0] a;
        total = 0; bad = 0; rsp_cnt = 0; force_delay = -1;
        inject_req = 0; inject_done = 0; rst_epoch = 0;
        m_axi_areset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; read_data = 0;
        repeat (3) @(posedge clk);
        #1 m_axi_areset = 0;
        @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("rst_count", 64'(cmd_count), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_pulses", 64'({write, read, rsp_valid}), 64'(0));
        @(posedge clk);
        #1;

        // Single write, pulse exactly two cycles after the push edge, then read it back.
        push_cmd(1'b1, 24'h000004, 32'h55555555, 1'b0);
        @(negedge clk); check("lat_edge0", 64'(write), 64'(0));
        @(negedge clk); check("lat_edge1", 64'(write), 64'(0));
        @(negedge clk); check("lat_edge2", 64'(write), 64'(1));
        wait_idle();
        push_cmd(1'b0, 24'h000004, 32'h0, 1'b0);
        wait_idle();

        // Back-to-back commands with a slow slave fill the FIFO; push while full with a same-cycle pop.
        force_delay = 4;
        push_cmd(1'b1, 24'h000100, 32'h12345678, 1'b0);
        push_cmd(1'b0, 24'h000100, 32'h0, 1'b0);
        push_cmd(1'b1, 24'h000004, 32'h00000000, 1'b0);
        push_cmd(1'b0, 24'h000004, 32'h0, 1'b0);
        push_cmd(1'b1, 24'h000008, 32'hA5A5A5A5, 1'b0);
        fork
            push_cmd(1'b0, 24'h000008, 32'h0, 1'b0);
            begin
                @(negedge clk);
                check("full_count", 64'(cmd_count), 64'(4));
                check("full_ready", 64'(cmd_ready), 64'(0));
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (cmd_count == 3'd4 && n < 50);
                check("full_pop_count", 64'(cmd_count), 64'(3));
            end
        join
        wait_idle();
        force_delay = -1;

        // Unanswered write: watchdog response 8 cycles after WAIT_B entry, then the next command runs.
        push_cmd(1'b1, 24'h000010, 32'hCAFEF00D, 1'b1);
        n = 0;
        do begin @(negedge clk); n++; end while (!write && n < 20);
        c1 = cyc;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
        c2 = cyc;
        check("timeout_latency", 64'(c2 - c1), 64'(8));
        @(posedge clk);
        #1;
        push_cmd(1'b0, 24'h000010, 32'h0, 1'b0);
        wait_idle();

        // Reset while waiting on R with two commands queued; a late R must be ignored.
        push_cmd(1'b0, 24'h000100, 32'h0, 1'b1);
        push_cmd(1'b0, 24'h000004, 32'h0, 1'b0);
        push_cmd(1'b0, 24'h000008, 32'h0, 1'b0);
        n = 0;
        do begin @(negedge clk); n++; end while (!read && n < 20);
        check("pre_reset_count", 64'(cmd_count), 64'(2));
        #5 m_axi_areset = 1;
        rst_epoch++;
        @(posedge clk);
        #1 m_axi_areset = 0;
        @(negedge clk);
        check("mid_rst_count", 64'(cmd_count), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_outputs", 64'({write, read, rsp_valid, rsp_timeout}), 64'(0));
        check("mid_rst_addr", 64'(read_address), 64'(0));
        exp_q.delete(); pulse_q.delete(); stub_q.delete();
        n = rsp_cnt;
        inject_req++;
        repeat (20) @(negedge clk);
        check("no_rsp_after_reset", 64'(rsp_cnt), 64'(n));
        @(posedge clk);
        #1;

        // Randomized traffic against the reference model.
        for (int i = 0; i < 150; i++) begin
            a = {1'($urandom % 8 == 0), 19'h0, 2'($urandom % 4), 2'b00};
            push_cmd(1'($urandom % 2), a, $urandom, 1'($urandom % 10 == 0));
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
